alu_issue_ctrl: RTL and testbench

//  Upstream issue stage for ALU_DESIGN. Buffers operand/command packets from the stimulus side
//  in a small FIFO (valid/ready) and issues them one at a time on the ALU input bus.

---
 rtl/alu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the ALU: buffers operand/command packets in a small FIFO and issues them one at
// a time, holding each on the bus for its result latency before pulsing res_sample.
module alu_issue_ctrl #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CMD_WIDTH = 4,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned BASE_LAT  = 1,
   parameter int unsigned MUL_LAT   = 2
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [WIDTH-1:0]             s_opa,
   input  logic [WIDTH-1:0]             s_opb,
   input  logic                         s_cin,
   input  logic                         s_mode,
   input  logic [CMD_WIDTH-1:0]         s_cmd,
   input  logic [1:0]                   s_inp_valid,
   output logic [WIDTH-1:0]             OPA,
   output logic [WIDTH-1:0]             OPB,
   output logic                         CIN,
   output logic                         MODE,
   output logic [CMD_WIDTH-1:0]         CMD,
   output logic [1:0]                   INP_VALID,
   output logic                         CE,
   output logic                         res_sample,
   output logic [CMD_WIDTH-1:0]         res_cmd,
   output logic                         res_mode,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         busy
);

   localparam int unsigned PW      = $clog2(DEPTH);
   localparam int unsigned LW      = $clog2(DEPTH + 1);
   localparam int unsigned PKT_W   = 2 * WIDTH + CMD_WIDTH + 4;
   localparam int unsigned MAX_LAT = (MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT;
   localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] BASE_CNT = CNT_W'(BASE_LAT - 1);

   logic [PKT_W-1:0]     r_mem [DEPTH];
   logic [PW-1:0]        r_wr_ptr;
   logic [PW-1:0]        r_rd_ptr;
   logic [LW-1:0]        r_level;
   logic                 r_ready;
   logic [1:0]           r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_opa;
   logic [WIDTH-1:0]     r_opb;
   logic                 r_cin;
   logic                 r_mode;
   logic [CMD_WIDTH-1:0] r_cmd;
   logic [1:0]           r_iv;

   logic                 w_push;
   logic                 w_pop;
   logic [LW-1:0]        w_level_nxt;
   logic [PKT_W-1:0]     w_head;
   logic                 w_is_mul;

   assign w_push   = s_valid && r_ready;
   assign w_pop    = (r_state == S_IDLE) && (r_level != '0);
   assign w_head   = r_mem[r_rd_ptr];
   assign w_is_mul = r_mode && ((r_cmd == CMD_WIDTH'(9)) || (r_cmd == CMD_WIDTH'(10)));

   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + LW'(1);
      end else if (w_pop && !w_push) begin
         w_level_nxt = r_level - LW'(1);
      end
   end

   // Storage has no reset; only pointers and occupancy define what is valid.
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {s_opa, s_opb, s_cin, s_mode, s_cmd, s_inp_valid};
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_ready  <= 1'b1;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_level <= w_level_nxt;
         r_ready <= (w_level_nxt != LW'(DEPTH));
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_opa   <= '0;
         r_opb   <= '0;
         r_cin   <= 1'b0;
         r_mode  <= 1'b0;
         r_cmd   <= '0;
         r_iv    <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_opa   <= w_head[CMD_WIDTH+4+WIDTH +: WIDTH];
                  r_opb   <= w_head[CMD_WIDTH+4 +: WIDTH];
                  r_cin   <= w_head[CMD_WIDTH+3];
                  r_mode  <= w_head[CMD_WIDTH+2];
                  r_cmd   <= w_head[CMD_WIDTH+1:2];
                  r_iv    <= w_head[1:0];
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_cnt   <= w_is_mul ? MUL_CNT : BASE_CNT;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_ready    = r_ready;
   assign level      = r_level;
   assign OPA        = r_opa;
   assign OPB        = r_opb;
   assign CIN        = r_cin;
   assign MODE       = r_mode;
   assign CMD        = r_cmd;
   assign CE         = (r_state != S_IDLE);
   assign busy       = (r_state != S_IDLE);
   assign INP_VALID  = (r_state != S_IDLE) ? r_iv : 2'b00;
   assign res_sample = (r_state == S_WAIT) && (r_cnt == '0);
   assign res_cmd    = r_cmd;
   assign res_mode   = r_mode;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: accepted packets are queued with their expected latency,
// and a monitor checks each issue window on the ALU bus.
module tb_alu_issue_ctrl;

   typedef struct packed {
      logic [7:0] opa;
      logic [7:0] opb;
      logic       cin;
      logic       mode;
      logic [3:0] cmd;
      logic [1:0] iv;
   } pkt_t;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [7:0] s_opa = '0;
   logic [7:0] s_opb = '0;
   logic       s_cin = 1'b0;
   logic       s_mode = 1'b0;
   logic [3:0] s_cmd = '0;
   logic [1:0] s_inp_valid = '0;
   logic [7:0] OPA;
   logic [7:0] OPB;
   logic       CIN;
   logic       MODE;
   logic [3:0] CMD;
   logic [1:0] INP_VALID;
   logic       CE;
   logic       res_sample;
   logic [3:0] res_cmd;
   logic       res_mode;
   logic [2:0] level;
   logic       busy;

   int   n_tests = 0;
   int   n_fail = 0;
   int   n_done = 0;
   int   n_full_pop = 0;
   bit   rst_done = 1'b0;
   bit   inflight = 1'b0;
   bit   full_armed = 1'b0;
   int   cyc = 0;
   pkt_t cur;
   pkt_t exp_q[$];

   alu_issue_ctrl #(
      .WIDTH(8), .CMD_WIDTH(4), .DEPTH(4), .BASE_LAT(1), .MUL_LAT(2)
   ) dut (
      .CLK(CLK), .RST(RST), .s_valid(s_valid), .s_ready(s_ready),
      .s_opa(s_opa), .s_opb(s_opb), .s_cin(s_cin), .s_mode(s_mode), .s_cmd(s_cmd),
      .s_inp_valid(s_inp_valid), .OPA(OPA), .OPB(OPB), .CIN(CIN), .MODE(MODE), .CMD(CMD),
      .INP_VALID(INP_VALID), .CE(CE), .res_sample(res_sample), .res_cmd(res_cmd),
      .res_mode(res_mode), .level(level), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int lat_of(input pkt_t p);
      return (p.mode && (p.cmd == 4'd9 || p.cmd == 4'd10)) ? 2 : 1;
   endfunction

   function automatic pkt_t mk(input logic [7:0] a, input logic [7:0] b, input logic c,
                               input logic m, input logic [3:0] cm, input logic [1:0] v);
      pkt_t p;
      p.opa = a; p.opb = b; p.cin = c; p.mode = m; p.cmd = cm; p.iv = v;
      return p;
   endfunction

   // Holds s_valid until the registered s_ready lets the packet in.
   task automatic push_op(input pkt_t p);
      int guard = 0;
      s_opa = p.opa; s_opb = p.opb; s_cin = p.cin; s_mode = p.mode;
      s_cmd = p.cmd; s_inp_valid = p.iv; s_valid = 1'b1;
      while (!s_ready && guard < 100) begin
         @(posedge CLK); #1;
         guard++;
      end
      chk("push_accept_timeout", {63'd0, s_ready}, 64'd1);
      if (s_ready) begin
         @(posedge CLK);
         exp_q.push_back(p);
         #1;
      end
      s_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while ((exp_q.size() != 0 || inflight || busy) && g < 200) begin
         @(posedge CLK); #1;
         g++;
      end
      chk("drain_timeout", {63'd0, g < 200}, 64'd1);
   endtask

   // Scoreboard monitor: one issue window per queued packet.
   always @(negedge CLK) begin
      if (!rst_done || RST) begin
         inflight = 1'b0;
      end else begin
         chk("busy_eq_ce", {63'd0, busy}, {63'd0, CE});
         if (CE && !inflight) begin
            chk("issue_expected", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
               cur = exp_q.pop_front();
               inflight = 1'b1;
               cyc = 0;
               chk("issue_bus", {40'd0, OPA, OPB, CIN, MODE, CMD, INP_VALID}, {40'd0, cur});
               chk("issue_no_res", {63'd0, res_sample}, 64'd0);
            end
         end else if (CE) begin
            cyc++;
            chk("wait_bus", {40'd0, OPA, OPB, CIN, MODE, CMD, INP_VALID}, {40'd0, cur});
            if (res_sample) begin
               chk("res_latency", 64'(cyc), 64'(lat_of(cur)));
               chk("res_cmd", {60'd0, res_cmd}, {60'd0, cur.cmd});
               chk("res_mode", {63'd0, res_mode}, {63'd0, cur.mode});
               inflight = 1'b0;
               n_done++;
            end else begin
               chk("res_not_late", {63'd0, cyc < lat_of(cur)}, 64'd1);
               if (cyc >= lat_of(cur)) inflight = 1'b0;
            end
         end else begin
            chk("idle_no_ce_mid_op", {63'd0, inflight}, 64'd0);
            inflight = 1'b0;
            chk("idle_outputs", {61'd0, res_sample, INP_VALID}, 64'd0);
         end
      end
   end

   // FIFO occupancy watcher, including full-with-pop rejection.
   always @(negedge CLK) begin
      if (rst_done && !RST) begin
         chk("ready_vs_level", {63'd0, s_ready}, {63'd0, level != 3'd4});
         if (full_armed) begin
            chk("full_pop_level", {61'd0, level}, 64'd3);
            n_full_pop++;
         end
         full_armed = (level == 3'd4) && !busy && s_valid && !s_ready;
      end else begin
         full_armed = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, required finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      chk("rst_ready", {63'd0, s_ready}, 64'd1);
      chk("rst_level", {61'd0, level}, 64'd0);
      chk("rst_ce_busy_res", {61'd0, CE, busy, res_sample}, 64'd0);
      chk("rst_bus", {40'd0, OPA, OPB, CIN, MODE, CMD, INP_VALID}, 64'd0);
      chk("rst_res_fields", {59'd0, res_cmd, res_mode}, 64'd0);
      rst_done = 1'b1;

      push_op(mk(8'h05, 8'h03, 1'b0, 1'b1, 4'd0, 2'b11));
      drain();
      chk("t1_level_zero", {61'd0, level}, 64'd0);

      push_op(mk(8'hA7, 8'h3C, 1'b1, 1'b1, 4'd9, 2'b11));
      drain();

      // Back-to-back burst fills the FIFO while multiplies occupy the issue slot.
      push_op(mk(8'h11, 8'h22, 1'b0, 1'b1, 4'd9, 2'b11));
      push_op(mk(8'h33, 8'h44, 1'b1, 1'b1, 4'd10, 2'b01));
      push_op(mk(8'h55, 8'h66, 1'b0, 1'b1, 4'd9, 2'b10));
      push_op(mk(8'h77, 8'h88, 1'b1, 1'b1, 4'd10, 2'b11));
      push_op(mk(8'h99, 8'hAA, 1'b0, 1'b1, 4'd9, 2'b11));
      push_op(mk(8'hBB, 8'hCC, 1'b1, 1'b0, 4'd3, 2'b11));
      drain();
      chk("full_pop_seen", {63'd0, n_full_pop > 0}, 64'd1);

      push_op(mk(8'h5A, 8'hA5, 1'b1, 1'b0, 4'd1, 2'b00));
      drain();

      // Reset lands in the first WAIT cycle of a multiply with two packets still queued.
      push_op(mk(8'hF0, 8'h0F, 1'b0, 1'b1, 4'd10, 2'b11));
      push_op(mk(8'h01, 8'h02, 1'b0, 1'b1, 4'd2, 2'b11));
      push_op(mk(8'h03, 8'h04, 1'b0, 1'b1, 4'd3, 2'b11));
      chk("t5_in_wait", {62'd0, CE, res_sample}, 64'd2);
      chk("t5_queued", {61'd0, level}, 64'd2);
      RST = 1'b1;
      exp_q.delete();
      @(posedge CLK); #1;
      RST = 1'b0;
      chk("t5_no_res", {63'd0, res_sample}, 64'd0);
      chk("t5_ce_low", {63'd0, CE}, 64'd0);
      chk("t5_level", {61'd0, level}, 64'd0);
      chk("t5_ready", {63'd0, s_ready}, 64'd1);
      repeat (4) @(posedge CLK);
      #1;
      chk("t5_stays_idle", {62'd0, CE, res_sample}, 64'd0);

      push_op(mk(8'hDE, 8'hAD, 1'b1, 1'b1, 4'd4, 2'b11));
      drain();
      chk("ops_completed", 64'(n_done), 64'd10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
